multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle RV32I control unit: the producer side of the ALU control interface. It fetches an instruction word, holds it in an internal instruction register, and sequences the datapath through an FSM. Each cycle it drives ALUctrl/BranchCtrl and the operand/result selects, and it consumes the ALU's Branch flag to resolve conditional branches. It sits between instruction/data memory and the register file/ALU datapath.

## Interface
- DATAWIDTH, 32, instruction and data word width; fixed at 32 for RV32I.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- MemReady_i  in  1  memory acknowledge for the current MemReq_o.
- InstrData_i  in  32  fetched word; valid when MemReady_i=1 in FETCH.
- Branch_i  in  1  ALU Branch_o (condition true).
- MemReq_o  out  1  memory access request.
- MemWrite_o  out  1  store request; only asserted together with MemReq_o.
- AdrSrc_o  out  1  memory address select: 0=PC, 1=ALUOut.
- IRWrite_o  out  1  datapath OldPC capture strobe.
- PCWrite_o  out  1  PC load strobe.
- RegWrite_o  out  1  register-file write enable.
- ALUSrcA_o  out  2  00=PC, 01=OldPC, 10=rs1, 11=zero.
- ALUSrcB_o  out  2  00=rs2, 01=imm, 10=constant 4.
- ImmSrc_o  out  3  000=I, 001=S, 010=B, 011=J, 100=U.
- ResultSrc_o  out  2  00=ALUOut register, 01=memory data, 10=ALUResult.
- ALUctrl_o  out  4  0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
- BranchCtrl_o  out  3  branch condition; equals funct3 in BRANCH, 000 otherwise.
- Instr_o  out  32  held instruction register.
- IllegalInstr_o  out  1  illegal-opcode flag.

## Operation
- States: RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JUMP, JALR, LINK, LUI, AUIPC, HALT.
- Outputs are Moore-decoded from the state and the IR, except where a handshake qualifier is stated. Undriven selects are 0, ALUctrl_o is ADD, and strobes are 0.
- RESET: all strobes 0. Moves to FETCH on the next edge.
- FETCH:
  - Drives MemReq_o=1, AdrSrc_o=0, ALUSrcA_o=00, ALUSrcB_o=10, ADD, ResultSrc_o=10.
  - IRWrite_o and PCWrite_o are asserted only while MemReady_i=1.
  - When MemReady_i=1, the IR loads InstrData_i and the state moves to DECODE. Otherwise the state stays in FETCH.
- DECODE: ALUSrcA_o=01, ALUSrcB_o=01, ADD, ImmSrc_o=B. This computes the branch target into ALUOut.
- Dispatch from DECODE on opcode:
  - 0000011 (load) and 0100011 (store) → MEMADR.
  - 0110011 → EXECR; 0010011 → EXECI.
  - 1100011 → BRANCH.
  - 1101111 (JAL) → JUMP, with ImmSrc_o=J in DECODE.
  - 1100111 → JALR; 0110111 → LUI; 0010111 → AUIPC.
  - Any other opcode → illegal (see Configuration).
- MEMADR: rs1+imm (ImmSrc_o=I for loads, S for stores). Next state is MEMREAD or MEMWRITE.
- MEMREAD and MEMWRITE: MemReq_o=1, AdrSrc_o=1; MemWrite_o=1 in MEMWRITE. Each waits for MemReady_i. MEMREAD then goes to MEMWB; MEMWRITE goes to FETCH.
- MEMWB: ResultSrc_o=01, RegWrite_o=1.
- EXECR and EXECI ALUctrl_o decode from funct3:
  - 000: ADD, or SUB only when EXECR and funct7[5]=1.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101: SRL, or SRA when funct7[5]=1.
  - 110 OR, 111 AND.
- EXECR and EXECI both go to ALUWB. ALUWB: ResultSrc_o=00, RegWrite_o=1.
- BRANCH: ALUSrcA_o=10, ALUSrcB_o=00, SUB, BranchCtrl_o=funct3, ResultSrc_o=00, PCWrite_o=Branch_i. Next state is FETCH.
- JUMP: PCWrite_o=1, ResultSrc_o=00. Next state is LINK.
- JALR: ALUSrcA_o=10, ALUSrcB_o=01, ImmSrc_o=I, ADD, ResultSrc_o=10, PCWrite_o=1. Next state is LINK.
- LINK: ALUSrcA_o=01, ALUSrcB_o=10, ADD, ResultSrc_o=10, RegWrite_o=1.
- LUI: ALUSrcA_o=11, ALUSrcB_o=01, ImmSrc_o=U, ADD. Next state is ALUWB.
- AUIPC: same as LUI but ALUSrcA_o=01.
- MEMWB, ALUWB and LINK all go to FETCH.

## Timing
- Reset values:
  - State is RESET and the IR holds 32'h0000_0013 (NOP).
  - MemReq_o, MemWrite_o, IRWrite_o, PCWrite_o, RegWrite_o and IllegalInstr_o are 0.
  - All selects are 0, ALUctrl_o=0000, BranchCtrl_o=000.
- Cycles per instruction, with zero-wait memory (MemReady_i=1 on the first request cycle):
  - Branch: 3.
  - R-type, I-type, store: 4.
  - LUI, AUIPC, JAL, JALR: 4.
  - Load: 5.
- Each wait cycle adds 1.
- MemReq_o stays asserted, and the address select stays stable, until the cycle in which MemReady_i=1.
- MemReady_i has no effect when MemReq_o=0.
- rst asserted mid-instruction: the state goes to RESET immediately and all strobes drop asynchronously. An in-progress memory request is abandoned.

## Configuration
- CTRL_ILLEGAL_HALT_EN defined:
  - An illegal opcode in DECODE goes to HALT.
  - HALT: all strobes 0 and IllegalInstr_o=1 (sticky). Only rst exits HALT.
- CTRL_ILLEGAL_HALT_EN undefined:
  - An illegal opcode goes to FETCH, so it executes as a NOP (PC already advanced by 4).
  - IllegalInstr_o is tied to 0.

## Test plan
- Reset, then InstrData_i=0x002081B3 (add x3,x1,x2) with MemReady_i=1 → state sequence FETCH, DECODE, EXECR (ALUctrl_o=0000), ALUWB (RegWrite_o=1, ResultSrc_o=00); 4 cycles total.
- 0x40208133 (sub) → ALUctrl_o=0001 in EXECR. 0x4020D093 (srai) → ALUctrl_o=0111 in EXECI.
- 0x00208463 (beq) with Branch_i=1 → BranchCtrl_o=000, PCWrite_o=1 in BRANCH. With Branch_i=0 → PCWrite_o=0. Next state FETCH either way.
- Load 0x0040A183 with MemReady_i held 0 for 3 cycles in MEMREAD → MemReq_o=1 and AdrSrc_o=1 held throughout. On ready, MEMWB asserts RegWrite_o=1 with ResultSrc_o=01. Total 8 cycles.
- JAL 0x008000EF → JUMP (PCWrite_o=1, ResultSrc_o=00), then LINK (RegWrite_o=1, ALUSrcA_o=01, ALUSrcB_o=10).
- Opcode 0x0000007F → with CTRL_ILLEGAL_HALT_EN: HALT, IllegalInstr_o=1 until rst. Without it: back to FETCH and IllegalInstr_o=0. Separately, asserting rst in MEMWRITE drops MemWrite_o the same cycle.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control-unit bus: memory handshake, ALU branch flag and all datapath control lines.
interface multicycle_ctrl_if;
  logic        MemReady_i;
  logic [31:0] InstrData_i;
  logic        Branch_i;
  logic        MemReq_o;
  logic        MemWrite_o;
  logic        AdrSrc_o;
  logic        IRWrite_o;
  logic        PCWrite_o;
  logic        RegWrite_o;
  logic [1:0]  ALUSrcA_o;
  logic [1:0]  ALUSrcB_o;
  logic [2:0]  ImmSrc_o;
  logic [1:0]  ResultSrc_o;
  logic [3:0]  ALUctrl_o;
  logic [2:0]  BranchCtrl_o;
  logic [31:0] Instr_o;
  logic        IllegalInstr_o;

  modport master (
    input  MemReady_i, InstrData_i, Branch_i,
    output MemReq_o, MemWrite_o, AdrSrc_o, IRWrite_o, PCWrite_o, RegWrite_o,
           ALUSrcA_o, ALUSrcB_o, ImmSrc_o, ResultSrc_o, ALUctrl_o, BranchCtrl_o,
           Instr_o, IllegalInstr_o
  );

  modport slave (
    output MemReady_i, InstrData_i, Branch_i,
    input  MemReq_o, MemWrite_o, AdrSrc_o, IRWrite_o, PCWrite_o, RegWrite_o,
           ALUSrcA_o, ALUSrcB_o, ImmSrc_o, ResultSrc_o, ALUctrl_o, BranchCtrl_o,
           Instr_o, IllegalInstr_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with instruction register and registered Moore outputs.
// Optional CTRL_ILLEGAL_HALT_EN: illegal opcodes park the FSM in HALT with a sticky flag.
module multicycle_ctrl #(
  parameter int DATAWIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JUMP, S_JALR, S_LINK, S_LUI,
    S_AUIPC, S_HALT
  } state_t;

  typedef struct packed {
    logic       memreq;
    logic       memwrite;
    logic       adrsrc;
    logic       pcwrite;
    logic       regwrite;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] imm;
    logic [1:0] res;
    logic [3:0] alu;
    logic [2:0] br;
  } ctl_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [DATAWIDTH-1:0] NOP = 32'h0000_0013;

  state_t               r_state;
  logic [DATAWIDTH-1:0] r_ir;
  ctl_t                 r_ctl;
  state_t               w_next;
  logic [DATAWIDTH-1:0] w_ir_next;
  logic                 w_fetch_ack;

  function automatic logic [3:0] f_aluop(logic [2:0] f3, logic f7b5, logic is_r);
    case (f3)
      3'b000:  return (is_r && f7b5) ? 4'b0001 : 4'b0000;
      3'b001:  return 4'b0010;
      3'b010:  return 4'b0011;
      3'b011:  return 4'b0100;
      3'b100:  return 4'b0101;
      3'b101:  return f7b5 ? 4'b0111 : 4'b0110;
      3'b110:  return 4'b1000;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic state_t f_next(state_t s, logic [6:0] op, logic rdy);
    case (s)
      S_RESET:    return S_FETCH;
      S_FETCH:    return rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: return S_MEMADR;
          OP_R:              return S_EXECR;
          OP_I:              return S_EXECI;
          OP_BR:             return S_BRANCH;
          OP_JAL:            return S_JUMP;
          OP_JALR:           return S_JALR;
          OP_LUI:            return S_LUI;
          OP_AUIPC:          return S_AUIPC;
`ifdef CTRL_ILLEGAL_HALT_EN
          default:           return S_HALT;
`else
          default:           return S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   return (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  return rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: return rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_LUI, S_AUIPC: return S_ALUWB;
      S_JUMP, S_JALR:                   return S_LINK;
      S_MEMWB, S_ALUWB, S_LINK, S_BRANCH: return S_FETCH;
      S_HALT:     return S_HALT;
      default:    return S_RESET;
    endcase
  endfunction

  // Outputs for the state being entered, so they are valid from the first cycle of that state.
  function automatic ctl_t f_outs(state_t s, logic [6:0] op, logic [2:0] f3, logic f7b5);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.memreq = 1'b1; c.srcb = 2'b10; c.res = 2'b10; end
      S_DECODE:   begin c.srca = 2'b01; c.srcb = 2'b01; c.imm = (op == OP_JAL) ? 3'b011 : 3'b010; end
      S_MEMADR:   begin c.srca = 2'b10; c.srcb = 2'b01; c.imm = (op == OP_STORE) ? 3'b001 : 3'b000; end
      S_MEMREAD:  begin c.memreq = 1'b1; c.adrsrc = 1'b1; end
      S_MEMWRITE: begin c.memreq = 1'b1; c.adrsrc = 1'b1; c.memwrite = 1'b1; end
      S_MEMWB:    begin c.res = 2'b01; c.regwrite = 1'b1; end
      S_EXECR:    begin c.srca = 2'b10; c.alu = f_aluop(f3, f7b5, 1'b1); end
      S_EXECI:    begin c.srca = 2'b10; c.srcb = 2'b01; c.alu = f_aluop(f3, f7b5, 1'b0); end
      S_ALUWB:    c.regwrite = 1'b1;
      S_BRANCH:   begin c.srca = 2'b10; c.alu = 4'b0001; c.br = f3; end
      S_JUMP:     c.pcwrite = 1'b1;
      S_JALR:     begin c.srca = 2'b10; c.srcb = 2'b01; c.res = 2'b10; c.pcwrite = 1'b1; end
      S_LINK:     begin c.srca = 2'b01; c.srcb = 2'b10; c.res = 2'b10; c.regwrite = 1'b1; end
      S_LUI:      begin c.srca = 2'b11; c.srcb = 2'b01; c.imm = 3'b100; end
      S_AUIPC:    begin c.srca = 2'b01; c.srcb = 2'b01; c.imm = 3'b100; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  assign w_fetch_ack = (r_state == S_FETCH) && bus.MemReady_i;
  assign w_ir_next   = w_fetch_ack ? bus.InstrData_i : r_ir;
  assign w_next      = f_next(r_state, r_ir[6:0], bus.MemReady_i);

`ifdef CTRL_ILLEGAL_HALT_EN
  logic r_illegal;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RESET;
      r_ir    <= NOP;
      r_ctl   <= '0;
`ifdef CTRL_ILLEGAL_HALT_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_ir    <= w_ir_next;
      r_ctl   <= f_outs(w_next, w_ir_next[6:0], w_ir_next[14:12], w_ir_next[30]);
`ifdef CTRL_ILLEGAL_HALT_EN
      if (w_next == S_HALT) r_illegal <= 1'b1;
`endif
    end
  end

  // Handshake-qualified strobes: fetch acknowledge and the ALU branch condition.
  assign bus.IRWrite_o    = w_fetch_ack;
  assign bus.PCWrite_o    = r_ctl.pcwrite | w_fetch_ack | ((r_state == S_BRANCH) && bus.Branch_i);
  assign bus.MemReq_o     = r_ctl.memreq;
  assign bus.MemWrite_o   = r_ctl.memwrite;
  assign bus.AdrSrc_o     = r_ctl.adrsrc;
  assign bus.RegWrite_o   = r_ctl.regwrite;
  assign bus.ALUSrcA_o    = r_ctl.srca;
  assign bus.ALUSrcB_o    = r_ctl.srcb;
  assign bus.ImmSrc_o     = r_ctl.imm;
  assign bus.ResultSrc_o  = r_ctl.res;
  assign bus.ALUctrl_o    = r_ctl.alu;
  assign bus.BranchCtrl_o = r_ctl.br;
  assign bus.Instr_o      = r_ir;
`ifdef CTRL_ILLEGAL_HALT_EN
  assign bus.IllegalInstr_o = r_illegal;
`else
  assign bus.IllegalInstr_o = 1'b0;
`endif

endmodule
